// File: rtl/hdmi_pll_sequencer_if.sv
// Control/status bundle between the rPLL sequencer and its environment.
// master drives enable and the raw PLL lock; slave is the sequencer itself.
interface hdmi_pll_sequencer_if #(
    parameter int MAX_RETRIES = 4
);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          enable;
    logic          pll_lock;
    logic          pll_reset;
    logic          out_rst_n;
    logic          fault;
    logic [2:0]    state;
    logic [RW-1:0] retries;
    logic [7:0]    loss_count;

    modport master (
        output enable,
        output pll_lock,
        input  pll_reset,
        input  out_rst_n,
        input  fault,
        input  state,
        input  retries,
        input  loss_count
    );

    modport slave (
        input  enable,
        input  pll_lock,
        output pll_reset,
        output out_rst_n,
        output fault,
        output state,
        output retries,
        output loss_count
    );
endinterface

// File: rtl/hdmi_pll_sequencer.sv
// Power-up / recovery sequencer for the HDMI rPLL: reset pulse, lock wait with
// timeout and retry, lock-stable qualification, then release of downstream reset.
module hdmi_pll_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    hdmi_pll_sequencer_if.slave  bus
);
    localparam int RW     = $clog2(MAX_RETRIES + 1);
    localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d;
    logic [7:0]    loss_count_q, loss_count_d;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          pll_reset_q;
    logic          out_rst_n_q;
    logic          fault_q;

    // PLL LOCK is asynchronous to clkin; two flops before anything looks at it.
    assign lock_s = sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retries_d    = retries_q;
        loss_count_d = loss_count_q;

        if (!bus.enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // retries_q == RETRY_LAST means this timeout is the last one allowed
                        retries_d = retries_q + 1'b1;
                        cnt_d     = '0;
                        state_d   = (retries_q == RETRY_LAST) ? ST_FAULT : ST_RESET;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        if (loss_count_q != 8'hFF) begin
                            loss_count_d = loss_count_q + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retries_q    <= '0;
            loss_count_q <= '0;
            sync_q       <= '0;
            pll_reset_q  <= 1'b1;
            out_rst_n_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            loss_count_q <= loss_count_d;
            sync_q       <= {sync_q[0], bus.pll_lock};
            pll_reset_q  <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAULT);
            out_rst_n_q  <= (state_d == ST_RUN);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.out_rst_n  = out_rst_n_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;
    assign bus.retries    = retries_q;
    assign bus.loss_count = loss_count_q;
endmodule

// File: doc/hdmi_pll_sequencer.md
# hdmi_pll_sequencer

Power-up and recovery sequencer for the HDMI pixel/serial rPLL. It drives the PLL reset, waits for lock with a timeout, and holds a downstream reset until lock has been stable. It retries on lock timeout, latches a fault after repeated failures, and re-sequences on lock loss. It runs on the free-running PLL input clock and sits between board reset and the TMDS/video-timing logic.

## Interface
- RESET_CYCLES, default 16: cycles `pll_reset` is held high per attempt (≥1).
- LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before an attempt fails (≥2).
- STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRIES, default 4: lock timeouts tolerated; the MAX_RETRIES-th timeout enters FAULT (≥1).
- clkin  input  1  free-running reference clock (PLL CLKIN); all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  level; high requests PLL bring-up, low returns to IDLE from any state.
- pll_lock  input  1  PLL LOCK, asynchronous; internal 2-flop synchronizer produces lock_s.
- pll_reset  output  1  to PLL RESET; high = PLL held in reset.
- out_rst_n  output  1  active-low reset for downstream pixel-domain logic (downstream re-synchronizes).
- fault  output  1  high in FAULT.
- state  output  3  IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- retries  output  $clog2(MAX_RETRIES+1)  timeouts in the current bring-up.
- loss_count  output  8  lock-loss events seen in RUN, saturating at 255.

## Operation
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Reset (rst_n low at an edge): state=IDLE, pll_reset=1, out_rst_n=0, fault=0, retries=0, loss_count=0, counters=0, synchronizer=0.
- enable low at any edge (rst_n high) forces IDLE. retries is cleared. loss_count is kept.
- IDLE: pll_reset=1, out_rst_n=0. If enable is high, go to RESET and clear the counter.
- RESET: pll_reset=1. Stay for RESET_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1: go to STABLE.
  - Otherwise the counter increments. On reaching LOCK_TIMEOUT, retries increments.
  - After a timeout: if the new retries equals MAX_RETRIES, go to FAULT; otherwise go to RESET.
- STABLE: pll_reset=0.
  - The counter increments while lock_s=1.
  - lock_s=0: return to WAIT_LOCK with the counter cleared. The timeout restarts; retries is unchanged.
  - After STABLE_CYCLES consecutive high cycles: go to RUN, set out_rst_n=1, clear retries.
- RUN: out_rst_n=1, pll_reset=0. On lock_s=0: go to RESET, set out_rst_n=0, and increment loss_count unless it is already 255.
- FAULT: pll_reset=1, out_rst_n=0, fault=1. Exit only via enable low or rst_n low.
- Precedence at an edge: rst_n, then enable low, then the FSM transition.
- Counter width is $clog2(max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1) and the counter never wraps.

## Timing
- enable sampled high at edge k: state=RESET from k. At edge k+RESET_CYCLES the state is WAIT_LOCK and pll_reset=0.
- pll_lock rising before edge m: lock_s=1 after edge m+1, state=STABLE at edge m+2.
- out_rst_n rises at edge m+2+STABLE_CYCLES if lock is held throughout.
- Timeout: WAIT_LOCK entered at edge w with no lock → state changes at edge w+LOCK_TIMEOUT.
- Lock loss in RUN: pll_lock falls before edge n → out_rst_n=0 and state=RESET at edge n+2.
- Glitches on pll_lock shorter than one clkin period may be missed. This is acceptable.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
- Clean bring-up.
  - Stimulus: enable at edge 10, pll_lock raised 5 cycles after pll_reset falls.
  - Required: pll_reset falls at edge 14, STABLE at edge 21, out_rst_n=1 and state=4 at edge 29, retries=0.
- Lock timeouts to FAULT.
  - Stimulus: pll_lock tied low.
  - Required: three attempts of 4 reset + 20 wait cycles, retries goes 1→2→3, FAULT at edge 10+72, fault=1, pll_reset=1.
  - Then enable low: IDLE next edge, fault=0, retries=0.
- Stable-window glitch.
  - Stimulus: lock high, dropped for 2 cycles at STABLE cycle 5, then held.
  - Required: return to WAIT_LOCK, re-enter STABLE, full 8 more cycles before out_rst_n=1, retries=0.
- Lock loss in RUN.
  - Stimulus: drop pll_lock at edge n.
  - Required: out_rst_n=0 and state=1 at n+2, loss_count=1, pll_reset high 4 cycles, re-lock returns to RUN.
  - 300 losses: loss_count saturates at 255.
- Reset mid-operation.
  - Stimulus: rst_n low for one edge while in STABLE and while in RUN.
  - Required: all outputs at reset values on that edge.
  - Then with enable held high: RESET on the first edge after rst_n returns high.
- Success after retries.
  - Stimulus: lock first asserted during the 2nd attempt.
  - Required: retries=1 while in STABLE, cleared to 0 on entering RUN, fault never asserted.
